// File: rtl/ads127l01_fsync_rx_if.sv
// Read/status bus between the ADS127L01 frame-sync receiver and the register slave.
// The receiver presents the FWFT head sample, fill level and sticky flags; the slave
// returns a pop strobe (DATA read) and a flag-clear pulse.
interface ads127l01_fsync_rx_if #(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned CNT_W = 5
);

  logic             rd_en;
  logic [OUT_W-1:0] rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             frame_err;
  logic             clr_flags;

  // Receiver side: produces samples and status.
  modport master (
    input  rd_en,
    input  clr_flags,
    output rd_data,
    output rd_valid,
    output count,
    output overflow,
    output frame_err
  );

  // Register-slave side: consumes samples and status.
  modport slave (
    output rd_en,
    output clr_flags,
    input  rd_data,
    input  rd_valid,
    input  count,
    input  overflow,
    input  frame_err
  );

endinterface

// File: rtl/ads127l01_fsync_rx.sv
// ADS127L01 frame-sync mode receiver.
// Synchronizes the ADC-driven sck/dout/fsync pins into the aclk domain, deserializes
// MSB-first DATA_W-bit conversions, sign-extends them to OUT_W bits and buffers them in
// a first-word-fall-through FIFO with sticky overflow / frame-error flags.
module ads127l01_fsync_rx #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned OUT_W       = 32,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        en,
  input  logic                        sck,
  input  logic                        dout,
  input  logic                        fsync,
  ads127l01_fsync_rx_if.master        rd_bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  localparam logic [BIT_W-1:0] LastBit = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StPush
  } state_e;

  // ---------------------------------------------------------------------------
  // Pin synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] dout_sync_q;
  logic [SYNC_STAGES-1:0] fsync_sync_q;
  logic                   sck_dly_q;
  logic                   fsync_dly_q;

  logic sck_rise;
  logic fsync_rise;
  logic dout_bit;

  // Shift each pin through its synchronizer chain; last stage also feeds a delay flop.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sck_sync_q   <= '0;
      dout_sync_q  <= '0;
      fsync_sync_q <= '0;
      sck_dly_q    <= 1'b0;
      fsync_dly_q  <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      dout_sync_q  <= {dout_sync_q[SYNC_STAGES-2:0], dout};
      fsync_sync_q <= {fsync_sync_q[SYNC_STAGES-2:0], fsync};
      sck_dly_q    <= sck_sync_q[SYNC_STAGES-1];
      fsync_dly_q  <= fsync_sync_q[SYNC_STAGES-1];
    end
  end

  // Single-cycle rising-edge pulses on the synchronized pins.
  always_comb begin
    sck_rise   = sck_sync_q[SYNC_STAGES-1] & ~sck_dly_q;
    fsync_rise = fsync_sync_q[SYNC_STAGES-1] & ~fsync_dly_q;
    dout_bit   = dout_sync_q[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Frame capture FSM
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic [BIT_W-1:0]  bitcnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              fsync_pend_q;
  logic              frame_err_q;

  logic clr_flags;
  assign clr_flags = rd_bus.clr_flags;

  // Deserialize one frame per fsync rise; restart (and flag) on a premature fsync.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= StIdle;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      fsync_pend_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (clr_flags) begin
        frame_err_q <= 1'b0;
      end
      if (!en) begin
        // Partial frame is abandoned silently; a PUSH already in flight still lands.
        state_q      <= StIdle;
        bitcnt_q     <= '0;
        shift_q      <= '0;
        fsync_pend_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (fsync_rise || fsync_pend_q) begin
              state_q      <= StShift;
              bitcnt_q     <= '0;
              shift_q      <= '0;
              fsync_pend_q <= 1'b0;
            end
          end
          StShift: begin
            if (fsync_rise) begin
              // bitcnt is 0..DATA_W-1 here; any captured bits mean a truncated frame.
              if ((bitcnt_q != '0) && !clr_flags) begin
                frame_err_q <= 1'b1;
              end
              if (sck_rise) begin
                // Coincident sck edge is bit 0 of the new frame.
                shift_q  <= {{(DATA_W-1){1'b0}}, dout_bit};
                bitcnt_q <= BIT_W'(1);
              end else begin
                shift_q  <= '0;
                bitcnt_q <= '0;
              end
            end else if (sck_rise) begin
              shift_q  <= {shift_q[DATA_W-2:0], dout_bit};
              bitcnt_q <= bitcnt_q + BIT_W'(1);
              if (bitcnt_q == LastBit) begin
                state_q <= StPush;
              end
            end
          end
          StPush: begin
            state_q      <= StIdle;
            // Remember an fsync that lands during the push so the next frame is not missed.
            fsync_pend_q <= fsync_rise;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             overflow_q;

  logic             push;
  logic             full;
  logic             empty;
  logic             do_rd;
  logic             do_wr;
  logic             drop;
  logic [OUT_W-1:0] push_word;

  // Push/pop qualification; a pop while full frees the slot for a same-cycle push.
  always_comb begin
    push      = (state_q == StPush);
    full      = (count_q == FullCnt);
    empty     = (count_q == '0);
    do_rd     = rd_bus.rd_en && !empty;
    do_wr     = push && (!full || do_rd);
    drop      = push && full && !do_rd;
    push_word = {{(OUT_W-DATA_W){shift_q[DATA_W-1]}}, shift_q};
    count_d   = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge aclk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // Pointers, fill level and sticky overflow; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (clr_flags) begin
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Head-of-FIFO presentation; zero while empty.
  always_comb begin
    rd_bus.rd_data   = empty ? '0 : mem_q[rd_ptr_q];
    rd_bus.rd_valid  = !empty;
    rd_bus.count     = count_q;
    rd_bus.overflow  = overflow_q;
    rd_bus.frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_ads127l01_fsync_rx.sv
// Self-checking bench for ads127l01_fsync_rx: directed scenarios followed by randomized
// frames/reads/flag-clears, all compared against a queue-based transaction model.
module tb_ads127l01_fsync_rx;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;

  logic aclk = 1'b0;
  logic areset;
  logic en;
  logic sck;
  logic dout;
  logic fsync;

  ads127l01_fsync_rx_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  ads127l01_fsync_rx #(
    .DATA_W     (DATA_W),
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .en    (en),
    .sck   (sck),
    .dout  (dout),
    .fsync (fsync),
    .rd_bus(bus)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: stored samples plus sticky flags.
  logic [31:0] exp_q[$];
  bit          exp_ovf;
  bit          exp_ferr;
  bit          partial_pending;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [23:0] v);
    int s;
    s = int'(v);
    if (v >= 24'h800000) s = s - (1 << 24);
    return 32'(s);
  endfunction

  function automatic void model_push(input logic [23:0] v);
    if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(sext(v));
  endfunction

  task automatic verify(input string tag);
    check_eq($sformatf("%s.count", tag), 32'(bus.count), 32'(exp_q.size()));
    check_eq($sformatf("%s.rd_valid", tag), 32'(bus.rd_valid), 32'(exp_q.size() != 0));
    check_eq($sformatf("%s.rd_data", tag), bus.rd_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    check_eq($sformatf("%s.overflow", tag), 32'(bus.overflow), 32'(exp_ovf));
    check_eq($sformatf("%s.frame_err", tag), 32'(bus.frame_err), 32'(exp_ferr));
  endtask

  // Drive one frame at sck = aclk/8; nbits < 24 leaves a truncated frame.
  task automatic send_frame(input logic [23:0] v, input int nbits, input bit rd_in_push,
                            input bit chk_lat);
    if (partial_pending && en) exp_ferr = 1'b1;
    partial_pending = 1'b0;
    @(negedge aclk);
    fsync = 1'b1;
    sck   = 1'b0;
    repeat (4) @(negedge aclk);
    for (int i = 0; i < nbits; i++) begin
      dout = v[23-i];
      repeat (4) @(negedge aclk);
      sck = 1'b1;
      if (i == nbits - 1 && chk_lat) begin
        // Synced edge is seen after 2 posedges; sample must appear 2 posedges later.
        repeat (3) @(posedge aclk);
        #1;
        check_eq("lat_early.rd_valid", 32'(bus.rd_valid), 32'(exp_q.size() != 0));
        @(posedge aclk);
        #1;
        check_eq("lat.rd_valid", 32'(bus.rd_valid), 32'h1);
        check_eq("lat.rd_data", bus.rd_data, (exp_q.size() != 0) ? exp_q[0] : sext(v));
        check_eq("lat.count", 32'(bus.count), 32'(exp_q.size() + 1));
        @(negedge aclk);
      end else if (i == nbits - 1 && rd_in_push) begin
        repeat (3) @(negedge aclk);
        check_eq("push_rd.head", bus.rd_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        bus.rd_en = 1'b1;
        @(negedge aclk);
        bus.rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        repeat (4) @(negedge aclk);
      end
      sck   = 1'b0;
      fsync = 1'b0;
    end
    if (nbits == 24) model_push(v);
    else partial_pending = (nbits > 0);
    repeat (4) @(negedge aclk);
  endtask

  task automatic do_read(input string tag);
    @(negedge aclk);
    check_eq($sformatf("%s.pre_data", tag), bus.rd_data,
             (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    bus.rd_en = 1'b1;
    @(negedge aclk);
    bus.rd_en = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic pulse_clr();
    @(negedge aclk);
    bus.clr_flags = 1'b1;
    @(negedge aclk);
    bus.clr_flags = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    areset        = 1'b1;
    en            = 1'b0;
    sck           = 1'b0;
    dout          = 1'b0;
    fsync         = 1'b0;
    bus.rd_en     = 1'b0;
    bus.clr_flags = 1'b0;
    exp_ovf         = 1'b0;
    exp_ferr        = 1'b0;
    partial_pending = 1'b0;
    repeat (4) @(negedge aclk);
    verify("reset");
    areset = 1'b0;
    en     = 1'b1;
    repeat (2) @(negedge aclk);

    // Single positive full-scale frame with latency check.
    send_frame(24'h7FFFFF, 24, 1'b0, 1'b1);
    verify("t1");
    check_eq("t1.const", bus.rd_data, 32'h007FFFFF);
    do_read("t1_rd");
    verify("t1_empty");

    // Back-to-back negative frames.
    send_frame(24'h800000, 24, 1'b0, 1'b0);
    send_frame(24'hFFFFFF, 24, 1'b0, 1'b0);
    verify("t2_two");
    check_eq("t2.head", bus.rd_data, 32'hFF800000);
    do_read("t2_rd0");
    verify("t2_one");
    do_read("t2_rd1");
    verify("t2_none");

    // Truncated frame followed by a good one.
    send_frame(24'($urandom), 10, 1'b0, 1'b0);
    send_frame(24'h123456, 24, 1'b0, 1'b0);
    verify("t3_err");
    pulse_clr();
    verify("t3_clr");
    do_read("t3_rd");

    // Overflow: 17 frames into a 16-deep FIFO.
    for (int v = 1; v <= 17; v++) send_frame(24'(v), 24, 1'b0, 1'b0);
    verify("t4_full");
    for (int k = 0; k < 16; k++) do_read($sformatf("t4_rd%0d", k));
    verify("t4_drained");

    // Full FIFO with a read in the PUSH cycle.
    pulse_clr();
    for (int k = 0; k < 16; k++) send_frame(24'($urandom), 24, 1'b0, 1'b0);
    send_frame(24'h00000A, 24, 1'b1, 1'b0);
    verify("t5_full_rd");
    for (int k = 0; k < 16; k++) do_read($sformatf("t5_rd%0d", k));
    verify("t5_drained");

    // Enable dropped mid-frame.
    send_frame(24'($urandom), 10, 1'b0, 1'b0);
    @(negedge aclk);
    en = 1'b0;
    repeat (3) @(negedge aclk);
    en = 1'b1;
    partial_pending = 1'b0;
    send_frame(24'hABCDEF, 24, 1'b0, 1'b0);
    verify("t6_en");
    check_eq("t6.const", bus.rd_data, 32'hFFABCDEF);

    // Reset mid-frame with a non-empty FIFO.
    send_frame(24'($urandom), 24, 1'b0, 1'b0);
    send_frame(24'($urandom), 10, 1'b0, 1'b0);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    exp_q.delete();
    exp_ovf         = 1'b0;
    exp_ferr        = 1'b0;
    partial_pending = 1'b0;
    verify("t6_rst");
    send_frame(24'h345678, 24, 1'b0, 1'b0);
    verify("t6_after_rst");

    // Randomized mix of frames, reads, truncations and flag clears.
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        send_frame(24'($urandom), 24, 1'b0, 1'b0);
      end else if (op <= 7) begin
        do_read($sformatf("rnd%0d_rd", it));
      end else if (op == 8) begin
        send_frame(24'($urandom), int'($urandom_range(1, 23)), 1'b0, 1'b0);
        send_frame(24'($urandom), 24, 1'b0, 1'b0);
      end else begin
        pulse_clr();
      end
      verify($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
